// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
//
// Run-time loadable DEPTH x DATA_WIDTH memory with a combinational read port.
// Each start launches one sequential load (address 0 .. DEPTH-1) fed by a
// valid/ready word stream. A running modulo-2^DATA_WIDTH checksum of the
// accepted words is kept alongside a count of words written.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : begin a load (honoured in IDLE or DONE)
//   abort     : cancel a load (honoured in LOAD, wins over start)
//   in_data   : word to write
//   in_valid  : in_data is valid
//   in_ready  : block accepts a word this cycle (high in LOAD)
//   rd_addr   : read address
//   rd_data   : mem[rd_addr], combinational
//   busy      : high while loading
//   done      : high after a full load completed, until the next start
//   wr_count  : words written in the current or last load
//   checksum  : sum of written words, mod 2^DATA_WIDTH
// ---------------------------------------------------------------------------
module mem_loader #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic [DATA_WIDTH-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic [DATA_WIDTH-1:0] sum_q;
    logic [DATA_WIDTH-1:0] sum_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  accept;

    // A word is only taken when the load is not being aborted in the same
    // cycle; abort suppresses the write even with in_valid high.
    assign in_ready = (state_q == LOAD);
    assign accept   = in_ready & in_valid & ~abort;

    assign ptr_d    = ptr_q + ADDR_WIDTH'(1);
    assign count_d  = count_q + (ADDR_WIDTH + 1)'(1);
    assign sum_d    = sum_q + in_data;

    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_count = count_q;
    assign checksum = sum_q;

    // Read port is purely combinational, so a same-cycle write to the
    // addressed location shows the old word until the edge.
    assign rd_data  = mem_q[rd_addr];

    // Storage is deliberately not reset so a reset leaves previously loaded
    // contents in place. Reset still blocks a pending write because it
    // forces the FSM out of LOAD, which drops in_ready and hence accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[ptr_q] <= in_data;
        end
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ptr_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        ptr_q   <= '0;
                        count_q <= '0;
                        sum_q   <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (in_valid) begin
                        ptr_q   <= ptr_d;
                        count_q <= count_d;
                        sum_q   <= sum_d;
                        // The pointer wraps back to 0 naturally on the last word.
                        if (ptr_q == LAST_ADDR) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_loader
//
// Self-checking bench for mem_loader. A behavioural model of the loader
// (plain counters, an array of words and "written" flags) tracks what the
// outputs must be; a negedge process compares the DUT against it every
// cycle. Directed scenarios pin the model with hand-computed literals,
// then a randomized phase exercises arbitrary start/abort/valid mixes.
// ---------------------------------------------------------------------------
module tb_mem_loader;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] rd_addr  = '0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;
    logic [DW-1:0] checksum;

    int nCompared   = 0;
    int nMismatched = 0;

    mem_loader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .wr_count(wr_count),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    bit      mLoading = 1'b0;
    bit      mDone    = 1'b0;
    int      mCount   = 0;
    int      mSum     = 0;
    int      mPtr     = 0;
    logic [DW-1:0] mMem   [DEPTH];
    bit            mKnown [DEPTH];

    // Model of the loader's observable rules, updated on each clock edge
    // (or immediately on reset) from the inputs held before the edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mLoading = 1'b0;
            mDone    = 1'b0;
            mCount   = 0;
            mSum     = 0;
            mPtr     = 0;
        end else if (!mLoading) begin
            if (start) begin
                mLoading = 1'b1;
                mDone    = 1'b0;
                mCount   = 0;
                mSum     = 0;
                mPtr     = 0;
            end
        end else if (abort) begin
            mLoading = 1'b0;
        end else if (in_valid) begin
            mMem[mPtr]   = in_data;
            mKnown[mPtr] = 1'b1;
            mSum         = (mSum + int'(in_data)) % 256;
            mCount       = mCount + 1;
            mPtr         = (mPtr + 1) % DEPTH;
            if (mCount == DEPTH) begin
                mLoading = 1'b0;
                mDone    = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        checkOutput("in_ready", 32'(in_ready), 32'(mLoading));
        checkOutput("busy",     32'(busy),     32'(mLoading));
        checkOutput("done",     32'(done),     32'(mDone));
        checkOutput("wr_count", 32'(wr_count), 32'(mCount));
        checkOutput("checksum", 32'(checksum), 32'(mSum));
        if (mKnown[rd_addr]) begin
            checkOutput("rd_data", 32'(rd_data), 32'(mMem[rd_addr]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, let the edge sample them, then drop the
    // single-cycle controls.
    task automatic applyStimulus(input logic st, input logic ab,
                                 input logic v, input logic [DW-1:0] d);
        start    = st;
        abort    = ab;
        in_valid = v;
        in_data  = d;
        tick();
        start    = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic startLoad();
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
    endtask

    // Stream words until done rises or a cycle budget expires; returns the
    // number of cycles spent.
    task automatic streamWords(input logic [DW-1:0] base, input logic [DW-1:0] step,
                               output int cycles);
        logic [DW-1:0] w;
        cycles = 0;
        w      = base;
        while (!done && cycles < 40) begin
            applyStimulus(1'b0, 1'b0, 1'b1, w);
            w = w + step;
            cycles++;
        end
        in_valid = 1'b0;
    endtask

    task automatic readCheck(input int addr, input logic [DW-1:0] exp, input string name);
        rd_addr = AW'(addr);
        #1;
        checkOutput(name, 32'(rd_data), 32'(exp));
        tick();
    endtask

    initial begin
        int cyc;

        $display("[TB] starting mem_loader bench");
        #2 rst = 1'b1;
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
        checkOutput("reset_busy",     32'(busy),     32'd0);
        checkOutput("reset_ready",    32'(in_ready), 32'd0);
        checkOutput("reset_wr_count", 32'(wr_count), 32'd0);
        checkOutput("reset_checksum", 32'(checksum), 32'd0);

        // Back-to-back load of 0x11..0x88.
        startLoad();
        checkOutput("load_busy", 32'(busy), 32'd1);
        streamWords(8'h11, 8'h11, cyc);
        checkOutput("b2b_cycles",   32'(cyc),      32'd8);
        checkOutput("b2b_done",     32'(done),     32'd1);
        checkOutput("b2b_wr_count", 32'(wr_count), 32'd8);
        checkOutput("b2b_checksum", 32'(checksum), 32'h64);
        for (int i = 0; i < DEPTH; i++) begin
            readCheck(i, 8'(8'h11 * (i + 1)), "b2b_read");
        end

        // Same load with in_valid toggling 1,0,1,0...
        startLoad();
        cyc = 0;
        while (!done && cyc < 40) begin
            if (cyc % 2 == 0) begin
                applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h11 * (cyc / 2 + 1)));
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom));
            end
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("toggle_cycles",   32'(cyc),      32'd15);
        checkOutput("toggle_checksum", 32'(checksum), 32'h64);
        for (int i = 0; i < DEPTH; i++) begin
            readCheck(i, 8'(8'h11 * (i + 1)), "toggle_read");
        end

        // Abort after three words, with in_valid high on the abort cycle.
        startLoad();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA2);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A);
        in_valid = 1'b0;
        checkOutput("abort_busy",     32'(busy),     32'd0);
        checkOutput("abort_done",     32'(done),     32'd0);
        checkOutput("abort_wr_count", 32'(wr_count), 32'd3);
        checkOutput("abort_checksum", 32'(checksum), 32'hE3);
        readCheck(3, 8'h44, "abort_mem3");
        readCheck(2, 8'hA2, "abort_mem2");

        // Reach DONE, then reload with 0xFF x8 (checksum wraps).
        startLoad();
        streamWords(8'h01, 8'h01, cyc);
        checkOutput("pre_done", 32'(done), 32'd1);
        startLoad();
        checkOutput("ff_done_drop", 32'(done), 32'd0);
        streamWords(8'hFF, 8'h00, cyc);
        checkOutput("ff_done",     32'(done),     32'd1);
        checkOutput("ff_checksum", 32'(checksum), 32'hF8);
        for (int i = 0; i < DEPTH; i++) begin
            readCheck(i, 8'hFF, "ff_read");
        end

        // start together with abort in LOAD: abort wins.
        startLoad();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h10);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h20);
        in_valid = 1'b0;
        checkOutput("both_busy",     32'(busy),     32'd0);
        checkOutput("both_wr_count", 32'(wr_count), 32'd1);

        // start pulsed mid-load is ignored.
        startLoad();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h30);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h31);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("midstart_busy",     32'(busy),     32'd1);
        checkOutput("midstart_wr_count", 32'(wr_count), 32'd2);
        streamWords(8'h32, 8'h01, cyc);
        checkOutput("midstart_cycles", 32'(cyc), 32'd6);
        checkOutput("midstart_done",   32'(done), 32'd1);

        // Asynchronous reset between edges mid-load.
        startLoad();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h77);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h78);
        in_valid = 1'b1;
        in_data  = 8'h79;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_busy",     32'(busy),     32'd0);
        checkOutput("arst_ready",    32'(in_ready), 32'd0);
        checkOutput("arst_done",     32'(done),     32'd0);
        checkOutput("arst_wr_count", 32'(wr_count), 32'd0);
        checkOutput("arst_checksum", 32'(checksum), 32'd0);
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b0;
        tick();
        startLoad();
        streamWords(8'h01, 8'h01, cyc);
        checkOutput("post_rst_cycles",   32'(cyc),      32'd8);
        checkOutput("post_rst_checksum", 32'(checksum), 32'h24);

        // Randomized phase against the model.
        for (int i = 0; i < 600; i++) begin
            rd_addr = AW'($urandom_range(0, DEPTH - 1));
            applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 3) != 0), 8'($urandom));
        end
        in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
